// File: rtl/jsv_pio_pkg.sv
// Shared definitions for the pulse-capable output PIO: register map, STATUS bit
// positions and the pulse FSM state encoding.
package jsv_pio_pkg;

   localparam logic [2:0] ADDR_DATA        = 3'd0;
   localparam logic [2:0] ADDR_PULSE_LEN   = 3'd1;
   localparam logic [2:0] ADDR_PULSE_START = 3'd2;
   localparam logic [2:0] ADDR_STATUS      = 3'd3;
   localparam logic [2:0] ADDR_OUTSET      = 3'd4;
   localparam logic [2:0] ADDR_OUTCLR      = 3'd5;
   localparam logic [2:0] ADDR_IRQ_EN      = 3'd6;
   localparam logic [2:0] ADDR_RSVD        = 3'd7;

   localparam int STAT_BUSY = 0;
   localparam int STAT_DONE = 1;
   localparam int STAT_OVR  = 2;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_PULSE = 1'b1
   } pulse_state_e;

endpackage

// File: rtl/jsv_pulse_timer.sv
// Pulse length timer: loads max(len,1) on start, counts down once per cycle and
// flags the final cycle so the owner can drop its mask on the same edge.
module jsv_pulse_timer
   import jsv_pio_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [CNT_W-1:0] len,
   output logic             busy,
   output logic             done_pulse,
   output logic [CNT_W-1:0] count,
   output pulse_state_e     state
);

   localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= ST_IDLE;
         busy  <= 1'b0;
         count <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state <= ST_PULSE;
                  busy  <= 1'b1;
                  count <= (len == '0) ? ONE : len;
               end
            end
            ST_PULSE: begin
               if (count == ONE) begin
                  state <= ST_IDLE;
                  busy  <= 1'b0;
                  count <= '0;
               end else if (count != '0) begin
                  count <= count - ONE;
               end
            end
            default: begin
               state <= ST_IDLE;
               busy  <= 1'b0;
               count <= '0;
            end
         endcase
      end
   end

   // High during the last pulse cycle; the edge that ends it sees this asserted.
   assign done_pulse = (state == ST_PULSE) && (count == ONE);

endmodule

// File: rtl/jsv_pio_pulse.sv
// Avalon-MM output PIO with atomic set/clear and a hardware-timed inversion pulse.
// Define JSV_PIO_PULSE_IRQ_EN to add the IRQ_EN register and the done interrupt.
module jsv_pio_pulse
   import jsv_pio_pkg::*;
#(
   parameter int               WIDTH         = 1,
   parameter int               CNT_W         = 16,
   parameter logic [WIDTH-1:0] RESET_VALUE   = '0,
   parameter int unsigned      DEFAULT_PULSE = 1000
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [2:0]       address,
   input  logic             chipselect,
   input  logic             write_n,
   input  logic [31:0]      writedata,
   output logic [31:0]      readdata,
   output logic [WIDTH-1:0] out_port,
   output logic             irq
);

   localparam logic [CNT_W-1:0] PULSE_RST = CNT_W'(DEFAULT_PULSE);

   // Bus contract: a write is chipselect & ~write_n sampled at posedge clk and
   // lands on that edge; reads are combinational from address with no wait states.
   logic wr;
   assign wr = chipselect & ~write_n;

   logic [WIDTH-1:0] data_out;
   logic [WIDTH-1:0] pulse_mask;
   logic [CNT_W-1:0] pulse_len;
   logic [CNT_W-1:0] count;
   logic             busy;
   logic             done_pulse;
   logic             done;
   logic             ovr;
   pulse_state_e     timer_state;

   logic start_req;
   logic start_ok;
   assign start_req = wr && (address == ADDR_PULSE_START);
   assign start_ok  = start_req && !busy && (writedata[WIDTH-1:0] != '0);

   jsv_pulse_timer #(.CNT_W(CNT_W)) u_timer (
      .clk        (clk),
      .reset      (reset),
      .start      (start_ok),
      .len        (pulse_len),
      .busy       (busy),
      .done_pulse (done_pulse),
      .count      (count),
      .state      (timer_state)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         data_out   <= RESET_VALUE;
         pulse_len  <= PULSE_RST;
         pulse_mask <= '0;
         done       <= 1'b0;
         ovr        <= 1'b0;
      end else begin
         if (wr) begin
            case (address)
               ADDR_DATA:      data_out  <= writedata[WIDTH-1:0];
               ADDR_OUTSET:    data_out  <= data_out | writedata[WIDTH-1:0];
               ADDR_OUTCLR:    data_out  <= data_out & ~writedata[WIDTH-1:0];
               ADDR_PULSE_LEN: pulse_len <= writedata[CNT_W-1:0];
               default: ;
            endcase
         end

         // start_ok needs !busy and done_pulse needs busy, so they never coincide.
         if (start_ok) begin
            pulse_mask <= writedata[WIDTH-1:0];
         end else if (done_pulse) begin
            pulse_mask <= '0;
         end

         // Hardware set beats a same-edge write-1-to-clear.
         if (done_pulse) begin
            done <= 1'b1;
         end else if (wr && (address == ADDR_STATUS) && writedata[STAT_DONE]) begin
            done <= 1'b0;
         end

         if (start_req && busy) begin
            ovr <= 1'b1;
         end else if (wr && (address == ADDR_STATUS) && writedata[STAT_OVR]) begin
            ovr <= 1'b0;
         end
      end
   end

`ifdef JSV_PIO_PULSE_IRQ_EN
   logic irq_en;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         irq_en <= 1'b0;
      end else if (wr && (address == ADDR_IRQ_EN)) begin
         irq_en <= writedata[0];
      end
   end

   assign irq = done & irq_en;
`else
   assign irq = 1'b0;
`endif

   always_comb begin
      readdata = '0;
      case (address)
         ADDR_DATA:        readdata = 32'(data_out);
         ADDR_PULSE_LEN:   readdata = 32'(pulse_len);
         ADDR_PULSE_START: readdata = 32'(count);
         ADDR_STATUS: begin
            readdata[STAT_BUSY] = busy;
            readdata[STAT_DONE] = done;
            readdata[STAT_OVR]  = ovr;
         end
`ifdef JSV_PIO_PULSE_IRQ_EN
         ADDR_IRQ_EN:      readdata[0] = irq_en;
`endif
         default:          readdata = '0;
      endcase
   end

   assign out_port = data_out ^ pulse_mask;

   // FSM state is kept for observation only; upper writedata bits may be unused.
   logic unused_sig;
   assign unused_sig = ^{writedata, timer_state};

endmodule
